// File: rtl/commit_scheduler.sv
// commit_scheduler: timestamps committed trigger patterns, queues them in a
// small first-word-fall-through FIFO for the readout side, and runs a
// holdoff FSM that vetoes the trigger logic while dead or full.
//
// state      | meaning
// -----------+---------------------------------------------------------
// DISARMED   | enable low; commits ignored and not counted, busy high
// ARMED      | accepting one commit, busy low
// DEAD       | holdoff running after an accepted commit, busy high
// FULL       | FIFO full after holdoff, busy high until a pop frees room
module commit_scheduler #(
    parameter int WIDTH    = 24,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 4,
    parameter int HOLDOFF  = 8
) (
    input  logic                      pll_clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      commit_valid,
    input  logic [WIDTH-1:0]          commit_data,
    output logic                      busy,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [TS_WIDTH+WIDTH-1:0] rd_data,
    output logic                      irq,
    output logic [$clog2(DEPTH):0]    count,
    output logic [7:0]                dropped,
    input  logic                      clr_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [7:0]    HOLDOFF_C = 8'(HOLDOFF);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_DEAD     = 2'd2,
        S_FULL     = 2'd3
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [TS_WIDTH-1:0]         ts;
    logic [7:0]                  holdoff_cnt;
    logic [TS_WIDTH+WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [CW-1:0]               count_q;
    logic [CW-1:0]               count_next;
    logic                        rd_valid_q;
    logic                        pop;
    logic                        room;
    logic                        push;
    logic                        drop;

    // A pop in the same cycle frees the slot a full FIFO needs for a push.
    assign pop  = rd_valid_q & rd_ready;
    assign room = (count_q < DEPTH_C) | pop;
    assign push = commit_valid & (state == S_ARMED) & room;
    assign drop = commit_valid & (state != S_DISARMED) & ~push;

    assign rd_valid = rd_valid_q;
    assign irq      = rd_valid_q;
    assign count    = count_q;
    assign rd_data  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; push+pop leaves it unchanged.
    always_comb begin
        count_next = count_q;
        if (push && !pop)
            count_next = count_q + 1'b1;
        else if (pop && !push)
            count_next = count_q - 1'b1;
    end

    // State register.
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset)
            state <= S_DISARMED;
        else
            state <= state_next;
    end

    // Next-state logic; dropping enable wins from any state.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = S_DISARMED;
        end else begin
            case (state)
                S_DISARMED: state_next = S_ARMED;
                S_ARMED:    if (push) state_next = S_DEAD;
                S_DEAD:     if (holdoff_cnt == 8'd1)
                                state_next = (count_next == DEPTH_C) ? S_FULL : S_ARMED;
                S_FULL:     if (pop) state_next = S_ARMED;
                default:    state_next = S_DISARMED;
            endcase
        end
    end

    // Veto output: only an armed scheduler lets triggers through.
    always_comb begin
        busy = 1'b1;
        if (state == S_ARMED)
            busy = 1'b0;
    end

    // Holdoff down-counter, loaded on every accepted commit.
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset)
            holdoff_cnt <= 8'd0;
        else if (push)
            holdoff_cnt <= HOLDOFF_C;
        else if (state == S_DEAD && holdoff_cnt != 8'd0)
            holdoff_cnt <= holdoff_cnt - 8'd1;
    end

    // Free-running timestamp.
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset)
            ts <= '0;
        else
            ts <= ts + 1'b1;
    end

    // FIFO storage, pointers and registered occupancy/valid.
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ts, commit_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q    <= count_next;
            rd_valid_q <= (count_next != '0);
        end
    end

    // Saturating lost-commit counter; a drop in the clear cycle still counts.
    always_ff @(posedge pll_clk or posedge reset) begin
        if (reset)
            dropped <= 8'd0;
        else if (clr_dropped)
            dropped <= drop ? 8'd1 : 8'd0;
        else if (drop && dropped != 8'hFF)
            dropped <= dropped + 8'd1;
    end

endmodule

// File: tb/tb_commit_scheduler.sv
// Self-checking bench for commit_scheduler: scoreboard of {timestamp, pattern}
// entries pushed on commit, popped and compared on each readout handshake.
module tb_commit_scheduler;

    logic        pll_clk;
    logic        reset;
    logic        enable;
    logic        commit_valid;
    logic [23:0] commit_data;
    logic        busy;
    logic        rd_valid;
    logic        rd_ready;
    logic [39:0] rd_data;
    logic        irq;
    logic [2:0]  count;
    logic [7:0]  dropped;
    logic        clr_dropped;

    logic [15:0] exp_ts;
    logic [39:0] sb [$];
    int          checks   = 0;
    int          failures = 0;

    commit_scheduler #(
        .WIDTH(24), .TS_WIDTH(16), .DEPTH(4), .HOLDOFF(8)
    ) dut (
        .pll_clk     (pll_clk),
        .reset       (reset),
        .enable      (enable),
        .commit_valid(commit_valid),
        .commit_data (commit_data),
        .busy        (busy),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .irq         (irq),
        .count       (count),
        .dropped     (dropped),
        .clr_dropped (clr_dropped)
    );

    initial begin
        pll_clk = 1'b0;
        forever #5 pll_clk = ~pll_clk;
    end

    // Expected free-running timestamp: cycles since reset released.
    always @(posedge pll_clk or posedge reset) begin
        if (reset)
            exp_ts <= 16'd0;
        else
            exp_ts <= exp_ts + 16'd1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: compare the head on a handshake, then advance to the next negedge.
    task automatic step();
        logic [39:0] exp_head;
        if (rd_valid && rd_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_head = sb.pop_front();
                chk("rd_data", 64'(rd_data), 64'(exp_head));
            end
        end
        @(posedge pll_clk);
        @(negedge pll_clk);
    endtask

    task automatic commit(input logic [23:0] d, input bit accept);
        commit_valid = 1'b1;
        commit_data  = d;
        if (accept)
            sb.push_back({exp_ts, d});
        step();
        commit_valid = 1'b0;
    endtask

    initial begin
        int hi;
        int guard;
        reset        = 1'b1;
        enable       = 1'b0;
        commit_valid = 1'b0;
        commit_data  = '0;
        rd_ready     = 1'b0;
        clr_dropped  = 1'b0;
        repeat (2) @(negedge pll_clk);

        chk("rst_busy",     64'(busy),     64'd1);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data",  64'(rd_data),  64'd0);
        chk("rst_irq",      64'(irq),      64'd0);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_dropped",  64'(dropped),  64'd0);

        // Basic commit at timestamp 0x0010 and holdoff length.
        reset  = 1'b0;
        enable = 1'b1;
        guard  = 0;
        while (exp_ts != 16'h0010 && guard < 100) begin
            step();
            guard++;
        end
        chk("wait_ts10", 64'(guard < 100), 64'd1);
        commit(24'hA5A5A5, 1'b1);
        chk("t1_rd_valid", 64'(rd_valid), 64'd1);
        chk("t1_rd_data",  64'(rd_data),  64'h0010A5A5A5);
        chk("t1_irq",      64'(irq),      64'd1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            hi++;
            step();
        end
        chk("holdoff_len", 64'(hi), 64'd8);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t1_drained", 64'(count), 64'd0);

        // Fill to FULL, drop in FULL, one pop re-arms.
        for (int k = 0; k < 4; k++) begin
            commit(24'h100000 + 24'(k), 1'b1);
            repeat (8) step();
        end
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_busy",  64'(busy),  64'd1);
        commit(24'hDEAD01, 1'b0);
        chk("t2_dropped", 64'(dropped), 64'd1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t2_rearm_busy", 64'(busy),  64'd0);
        chk("t2_count3",     64'(count), 64'd3);

        // Drop inside holdoff, clear, clear-with-drop, saturation.
        clr_dropped = 1'b1;
        step();
        clr_dropped = 1'b0;
        chk("t3_clr", 64'(dropped), 64'd0);
        commit(24'h200000, 1'b1);
        step();
        step();
        commit(24'hBAD003, 1'b0);
        chk("t3_dead_drop", 64'(dropped), 64'd1);
        clr_dropped = 1'b1;
        step();
        clr_dropped = 1'b0;
        chk("t3_clr2", 64'(dropped), 64'd0);
        repeat (4) step();
        chk("t3_full_count", 64'(count), 64'd4);
        clr_dropped = 1'b1;
        commit(24'h000000, 1'b0);
        clr_dropped = 1'b0;
        chk("t3_clr_with_drop", 64'(dropped), 64'd1);
        commit_valid = 1'b1;
        repeat (300) step();
        commit_valid = 1'b0;
        chk("t3_saturate", 64'(dropped), 64'd255);
        clr_dropped = 1'b1;
        step();
        clr_dropped = 1'b0;

        // Armed with a full FIFO: simultaneous push and pop.
        enable = 1'b0;
        step();
        chk("t4_disarm_busy", 64'(busy), 64'd1);
        enable = 1'b1;
        step();
        chk("t4_armed_busy", 64'(busy), 64'd0);
        rd_ready = 1'b1;
        commit(24'h300000, 1'b1);
        rd_ready = 1'b0;
        chk("t4_count_same", 64'(count), 64'd4);
        rd_ready = 1'b1;
        repeat (4) step();
        rd_ready = 1'b0;
        chk("t4_drained", 64'(count), 64'd0);
        repeat (4) step();
        chk("t4_rearmed", 64'(busy), 64'd0);
        for (int k = 0; k < 4; k++) begin
            commit(24'h400000 + 24'(k * 24'h111), 1'b1);
            repeat (8) step();
        end
        chk("t4_refill", 64'(count), 64'd4);
        rd_ready = 1'b1;
        repeat (5) step();
        rd_ready = 1'b0;
        chk("t4_empty_count", 64'(count),    64'd0);
        chk("t4_empty_valid", 64'(rd_valid), 64'd0);
        chk("t4_sb_empty",    64'(sb.size()), 64'd0);

        // Timestamp wrap.
        guard = 0;
        while (exp_ts != 16'hFFFE && guard < 70000) begin
            step();
            guard++;
        end
        chk("wait_tsfffe", 64'(guard < 70000), 64'd1);
        commit(24'hC0FFEE, 1'b1);
        repeat (8) step();
        commit(24'h00BEEF, 1'b1);
        chk("t5_head_ts", 64'(rd_data[39:24]), 64'hFFFE);
        rd_ready = 1'b1;
        repeat (2) step();
        rd_ready = 1'b0;
        repeat (6) step();

        // Reset mid-operation with entries queued and holdoff running.
        commit(24'h500001, 1'b1);
        repeat (8) step();
        commit(24'h500002, 1'b1);
        repeat (8) step();
        commit(24'h500003, 1'b1);
        step();
        chk("t6_pre_count", 64'(count), 64'd3);
        reset = 1'b1;
        #1;
        chk("t6_rst_count", 64'(count),    64'd0);
        chk("t6_rst_valid", 64'(rd_valid), 64'd0);
        chk("t6_rst_busy",  64'(busy),     64'd1);
        sb.delete();
        step();
        reset = 1'b0;
        step();
        chk("t6_busy_first_clk", 64'(busy), 64'd0);
        commit(24'h600000, 1'b1);
        chk("t6_ts_restart", 64'(rd_data[39:24]), 64'd1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/commit_scheduler.md
Name: commit_scheduler

Overview:
- Sequences committed trigger patterns out of the trigger datapath toward the MCU readout path.
- Each committed 24-bit hit pattern is tagged with a free-running timestamp and queued in a small FIFO. A dead-time (holdoff) FSM asserts busy toward the veto logic.
- The SPI side drains entries through a valid/ready handshake. Lost commits are counted.

Parameters:
- WIDTH, 24, hit-pattern width (one bit per comparator channel)
- TS_WIDTH, 16, timestamp width
- DEPTH, 4, FIFO entries; power of 2, ≥2
- HOLDOFF, 8, dead-time cycles after each accepted commit; range 1..255

Ports:
- pll_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  level; low = scheduler disarmed
- commit_valid  in  1  one-cycle pulse: commit_data is a committed pattern
- commit_data  in  WIDTH  committed hit pattern
- busy  out  1  veto request to trigger logic
- rd_valid  out  1  head entry available
- rd_ready  in  1  consumer accepts head this cycle
- rd_data  out  TS_WIDTH+WIDTH  {timestamp, pattern} of head entry
- irq  out  1  level: FIFO non-empty
- count  out  log2(DEPTH)+1  current occupancy
- dropped  out  8  saturating lost-commit counter
- clr_dropped  in  1  pulse: clear dropped

Behaviour:
- Reset values: busy=1, rd_valid=0, rd_data=0, irq=0, count=0, dropped=0, timestamp=0, FSM=DISARMED. Async assert; deassert takes effect on next pll_clk edge.
- Timestamp: free-running TS_WIDTH counter, +1 every cycle, wraps 2^TS_WIDTH-1 → 0. The value in the commit_valid cycle is stored.
- Write FSM states: DISARMED, ARMED, DEAD, FULL.
  - DISARMED: busy=1; commits ignored and not counted. Goes to ARMED when enable=1.
  - ARMED: busy=0.
    - commit_valid with room available → push, load holdoff counter with HOLDOFF, go to DEAD.
  - DEAD: busy=1; counter decrements each cycle.
    - At counter==1: go to FULL if count==DEPTH after this cycle's push/pop, else ARMED. The total dead time is exactly HOLDOFF cycles after the commit cycle.
    - commit_valid here → not pushed, dropped+1.
  - FULL: busy=1. Leave for ARMED on the cycle after a pop makes count<DEPTH.
    - commit_valid while full → dropped+1.
  - enable=0 in any state → DISARMED next cycle. FIFO contents are retained and remain drainable.
- "Room available" means count<DEPTH, or count==DEPTH with a pop in the same cycle. Simultaneous push and pop keeps count unchanged.
- FIFO is first-word-fall-through:
  - rd_valid = (count≠0), registered.
  - rd_data holds the head entry while rd_valid=1 and is stable until popped.
  - Pop happens when rd_valid & rd_ready. rd_ready while empty has no effect.
  - Latency: commit accepted at edge N → rd_valid=1 and correct rd_data after edge N+1 when the FIFO was empty.
- Pointers wrap modulo DEPTH. Ordering is strictly FIFO.
- irq equals rd_valid.
- dropped:
  - Saturates at 255.
  - clr_dropped alone → 0.
  - clr_dropped coinciding with a drop → 1.
- reset mid-operation: FIFO is emptied, pending holdoff is abandoned, timestamp restarts at 0.

Test Plan:
- Reset, enable=1, commit 0xA5A5A5 at timestamp 0x0010 → rd_valid=1 next cycle, rd_data=0x0010_A5A5A5, irq=1, busy high for exactly 8 cycles after commit, then 0.
- 4 commits spaced 9 cycles apart with rd_ready=0 → count=4, FSM FULL, busy=1. A 5th commit gives dropped=1. One pop → busy=0 one cycle later, count=3.
- Commit pulsed at 3 cycles after an accepted commit (inside holdoff) → not queued, dropped=1. clr_dropped alone → dropped=0. 300 commits in a full FIFO → dropped=255.
- Full FIFO, ARMED via pop timing, commit_valid and rd_ready in the same cycle → count stays 4, head advances, new entry stored at tail. Order verified over 8 drains.
- Timestamp near 0xFFFF: commits at 0xFFFE and 0x0007 (after wrap) → stored values exactly 0xFFFE and 0x0007.
- Assert reset for 1 cycle with 3 entries queued and DEAD active → count=0, rd_valid=0, busy=1 while reset is held. After release with enable=1 → busy=0 on the first clock, timestamp restarts at 0.
